mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port synchronous memory in system_top between the instruction-fetch
//  port and the load/store port of the core. Arbitrates requests and sequences each access
//  through a fixed-latency memory. Returns read data and a one-cycle ready pulse to the
//  winning requester. Sits between the core and the memory inside system_top.
// PARAMETERS
//  ADDR_W   32  address width, bits.
//  DATA_W   32  data width, bits.
//  MEM_LAT  1   memory read latency, cycles from mem_en to valid mem_rdata. Legal 1..4.
//  RR       1   1 = round-robin on ties; 0 = fixed priority, data port wins.
// PORTS
//  clk       in   1       system clock, rising edge.
//  rst       in   1       asynchronous reset, active-high.
//  if_req    in   1       fetch request; held with if_addr until if_ready.
//  if_addr   in   ADDR_W  fetch address.
//  if_rdata  out  DATA_W  fetch read data; valid while if_ready=1.
//  if_ready  out  1       one-cycle completion pulse for the fetch port.
//  d_req     in   1       data request; held with d_we/d_addr/d_wdata until d_ready.
//  d_we      in   1       1 = write, 0 = read.
//  d_addr    in   ADDR_W  data address.
//  d_wdata   in   DATA_W  write data.
//  d_rdata   out  DATA_W  data read result; valid while d_ready=1.
//  d_ready   out  1       one-cycle completion pulse for the data port.
//  mem_en    out  1       memory access strobe, one cycle per transaction.
//  mem_we    out  1       memory write enable; qualified by mem_en.
//  mem_addr  out  ADDR_W  memory address.
//  mem_wdata out  DATA_W  memory write data.
//  mem_rdata in   DATA_W  memory read data; valid MEM_LAT cycles after mem_en.
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, wait counter 0, last_served=DATA.
//    With RR=1, the first tie after reset goes to the fetch port.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Writes skip WAIT (ISSUE -> RESP).
//  - IDLE: sample if_req and d_req at the clock edge.
//    - Exactly one active: grant it.
//    - Both active, RR=1: grant the port not equal to last_served.
//    - Both active, RR=0: grant the data port.
//    - On grant: latch owner, we (forced 0 for fetch), addr and wdata into registers; go to ISSUE.
//  - ISSUE: mem_en=1 for exactly one cycle. mem_we/addr/wdata are driven from the latched
//    registers. Update last_served. Load the counter with MEM_LAT-1.
//  - WAIT: decrement the counter each cycle. At count 0, register mem_rdata into the owner's
//    rdata output and go to RESP.
//  - RESP: the owner's ready=1 for exactly one cycle. The rdata output holds its value until
//    the next read completes for that port. Next state is IDLE.
//  - Latency, req first sampled at cycle 0: mem_en in cycle 1.
//    - Read: ready in cycle MEM_LAT+2.
//    - Write: ready in cycle 2.
//    - Back-to-back throughput: one transaction per MEM_LAT+3 (read) or 3 (write) cycles.
//  - The losing requester keeps req high and is served next. RR=1 guarantees no starvation.
//    RR=0 can starve fetch.
//  - req dropped mid-transaction: ignored; the latched access completes and ready still pulses.
//    Requester inputs are not re-sampled until IDLE.
//  - At most one of if_ready/d_ready is high in any cycle. mem_en never asserts outside ISSUE.
//  - rst asserted mid-operation: immediate return to reset values, mem_en drops
//    asynchronously, the in-flight access is discarded, and no ready is produced.
//  - mem_addr/mem_wdata/mem_we hold their last latched values between transactions.
//  - MEM_LAT outside 1..4: elaboration error. The counter is 2 bits wide.
// STRUCTURE
//  - Shared package mem_bus_pkg: state encoding localparams (IDLE/ISSUE/WAIT/RESP) and
//    owner IDs (OWN_IF=0, OWN_D=1).
//  - One sub-module, arb_pick_2: combinational 2-way pick from (req0, req1, last, rr_en) to
//    grant id plus valid. Reused by later peripheral-bus arbiters.
//  - The FSM, counter and latches live in the top of this block.
// TESTING
//  1. Reset: rst=1 mid-read in WAIT
//     -> mem_en=0, if_ready=d_ready=0 immediately; no ready after release.
//  2. Lone fetch, MEM_LAT=1, if_addr=0x10, mem returns 0xDEADBEEF
//     -> mem_en in cycle 1; if_ready=1 and if_rdata=0xDEADBEEF in cycle 3.
//  3. Lone write, d_addr=0x40, d_wdata=0x1234
//     -> mem_en=mem_we=1 with those values in cycle 1; d_ready in cycle 2.
//  4. Both requesting continuously, RR=1 -> grants alternate IF,D,IF,D starting with IF.
//     Same stimulus, RR=0 -> D every time, fetch never served.
//  5. MEM_LAT=4 read -> ready in cycle 6; mem_en high for exactly one cycle.
//  6. Requester drops req in WAIT -> access completes; ready pulses once.
//     Next IDLE grants only live requests.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core memory-bus arbiter: FSM state encoding and
// requester identifiers used by the top and by testbenches.
package mem_bus_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_e;

endpackage

// File: rtl/arb_pick_2.sv
// Combinational two-way arbiter pick: chooses requester 0 or 1, alternating on
// ties when rr_en_i is set, otherwise giving requester 1 fixed priority.
module arb_pick_2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    input  logic rr_en_i,
    output logic gnt_o,
    output logic valid_o
);

    // Tie-break uses the previously served id so neither side can starve in RR mode.
    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = 1'b0;
        if (req0_i && req1_i) begin
            gnt_o = rr_en_i ? ~last_i : 1'b1;
        end else if (req1_i) begin
            gnt_o = 1'b1;
        end else begin
            gnt_o = 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one fixed-latency synchronous
// memory, sequencing each access IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int RR      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_lat_check
        $error("mem_bus_arbiter: MEM_LAT must be within 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e            state_q;
    logic              owner_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              mem_en_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              gnt_s;
    logic              gnt_valid_s;

    arb_pick_2 u_pick (
        .req0_i  (if_req),
        .req1_i  (d_req),
        .last_i  (last_q),
        .rr_en_i (RR != 0),
        .gnt_o   (gnt_s),
        .valid_o (gnt_valid_s)
    );

    // Latency counter: loaded while the strobe is out, counts down through WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE) begin
            cnt_d = CNT_INIT;
        end else if ((state_q == S_WAIT) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Transaction FSM; strobe and ready pulses are registered so they mark exactly one state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_D;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 2'd0;
            mem_en_q   <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            mem_en_q   <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            cnt_q      <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid_s) begin
                        state_q  <= S_ISSUE;
                        owner_q  <= gnt_s;
                        mem_en_q <= 1'b1;
                        if (gnt_s == OWN_D) begin
                            we_q    <= d_we;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                        end
                    end
                end
                S_ISSUE: begin
                    last_q <= owner_q;
                    if (we_q) begin
                        state_q <= S_RESP;
                        if (owner_q == OWN_D) begin
                            d_ready_q <= 1'b1;
                        end else begin
                            if_ready_q <= 1'b1;
                        end
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= S_RESP;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= mem_rdata;
                            d_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: three arbiter instances (LAT1/RR, LAT4/RR, LAT1/fixed)
// share requester stimulus; directed scenarios followed by randomized traffic.
module tb_mem_bus_arbiter;

    localparam int NI = 3;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        if_req  = 1'b0;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] d_addr  = 32'h0;
    logic [31:0] d_wdata = 32'h0;

    logic [31:0] if_rdata_a  [NI];
    logic [31:0] d_rdata_a   [NI];
    logic [31:0] mem_addr_a  [NI];
    logic [31:0] mem_wdata_a [NI];
    logic [31:0] mem_rdata_a [NI];
    logic        if_ready_a  [NI];
    logic        d_ready_a   [NI];
    logic        mem_en_a    [NI];
    logic        mem_we_a    [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h0100_0193) ^ 32'hA5A5_5A5A);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 4 : 1;
        localparam int RRV = (g == 2) ? 0 : 1;
        logic [31:0] pipe [4];

        mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .RR(RRV)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_rdata  (if_rdata_a[g]),
            .if_ready  (if_ready_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_rdata   (d_rdata_a[g]),
            .d_ready   (d_ready_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g])
        );

        // Memory model: read data appears exactly LAT cycles after the strobe, junk otherwise.
        always @(posedge clk) begin
            pipe[0] <= (mem_en_a[g] && !mem_we_a[g]) ? mem_val(mem_addr_a[g]) : 32'h0BAD_F00D;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata_a[g] = pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a falling edge with reset released: that cycle is cycle 0.
    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Transaction-level reference: each grant at cycle n gives strobe at n+1 and
    // ready at n+2 (write) or n+LAT+2 (read); the arbiter is free the cycle after ready.
    task automatic run_random(input int k, input int ncyc);
        int lat, free_at, en_at, rdy_at;
        bit rr, own, twe, last, busy;
        logic [31:0] taddr, twdata, exp_ifr, exp_dr, exp_ma;
        logic exp_mwe;
        lat = (k == 1) ? 4 : 1;
        rr  = (k != 2);
        reset_all();
        free_at = 0; en_at = -1; rdy_at = -1;
        own = 1'b0; twe = 1'b0; last = 1'b1;
        taddr = 32'h0; twdata = 32'h0; exp_ifr = 32'h0; exp_dr = 32'h0; exp_ma = 32'h0;
        exp_mwe = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            if (n == en_at) begin
                exp_ma  = taddr;
                exp_mwe = twe;
            end
            if ((n == rdy_at) && !twe) begin
                if (own) exp_dr = mem_val(taddr);
                else     exp_ifr = mem_val(taddr);
            end
            chkb("rnd_mem_en", mem_en_a[k], n == en_at);
            chkb("rnd_if_ready", if_ready_a[k], (n == rdy_at) && !own);
            chkb("rnd_d_ready", d_ready_a[k], (n == rdy_at) && own);
            chkb("rnd_mem_we", mem_we_a[k], exp_mwe);
            chk("rnd_mem_addr", mem_addr_a[k], exp_ma);
            chk("rnd_if_rdata", if_rdata_a[k], exp_ifr);
            chk("rnd_d_rdata", d_rdata_a[k], exp_dr);
            if ((n == en_at) && twe) chk("rnd_mem_wdata", mem_wdata_a[k], twdata);

            busy = (n >= en_at) && (n < rdy_at);
            if (n == rdy_at) begin
                if (own) d_req = 1'b0;
                else     if_req = 1'b0;
            end else if (busy && ($urandom_range(0, 15) == 0)) begin
                if (own) d_req = 1'b0;
                else     if_req = 1'b0;
            end
            if (!if_req && !(busy && !own) && ($urandom_range(0, 2) == 0)) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!d_req && !(busy && own) && ($urandom_range(0, 2) == 0)) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 63)) << 2;
                d_wdata = $urandom;
            end

            if ((n >= free_at) && (if_req || d_req)) begin
                own     = (if_req && d_req) ? (rr ? !last : 1'b1) : d_req;
                twe     = own && d_we;
                taddr   = own ? d_addr : if_addr;
                twdata  = d_wdata;
                en_at   = n + 1;
                rdy_at  = twe ? n + 2 : n + lat + 2;
                free_at = rdy_at + 1;
                last    = own;
            end
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        int seen, en_cnt, d_cnt, d_cyc, en_cyc;
        int seq0[$];
        int seq2[$];

        // Reset state on every instance.
        reset_all();
        for (int k = 0; k < NI; k++) begin
            chkb("rst_mem_en", mem_en_a[k], 1'b0);
            chkb("rst_if_ready", if_ready_a[k], 1'b0);
            chkb("rst_d_ready", d_ready_a[k], 1'b0);
            chk("rst_mem_addr", mem_addr_a[k], 32'h0);
            chk("rst_if_rdata", if_rdata_a[k], 32'h0);
        end

        // Reset while the strobe is out drops it without waiting for a clock.
        if_req = 1'b1; if_addr = 32'h20;
        step();
        for (int k = 0; k < NI; k++) chkb("t1_issue_en", mem_en_a[k], 1'b1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) chkb("t1_async_en", mem_en_a[k], 1'b0);
        if_req = 1'b0;

        // Reset during WAIT (LAT4) and RESP (LAT1): nothing completes afterwards.
        reset_all();
        if_req = 1'b1; if_addr = 32'h24;
        step(); step(); step();
        chkb("t1_pre_ready0", if_ready_a[0], 1'b1);
        rst = 1'b1;
        #1;
        chkb("t1_rst_ready0", if_ready_a[0], 1'b0);
        chkb("t1_rst_en1", mem_en_a[1], 1'b0);
        chkb("t1_rst_ready1", if_ready_a[1], 1'b0);
        if_req = 1'b0;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen += int'(if_ready_a[1]) + int'(d_ready_a[1]) + int'(mem_en_a[1]) + int'(if_ready_a[0]);
        end
        chk("t1_no_ready", 32'(seen), 32'h0);
        chk("t1_rdata_kept", if_rdata_a[1], 32'h0);

        // Lone fetch, LAT1.
        reset_all();
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chkb("t2_en_c1", mem_en_a[0], 1'b1);
        chk("t2_addr_c1", mem_addr_a[0], 32'h10);
        chkb("t2_we_c1", mem_we_a[0], 1'b0);
        step();
        chkb("t2_en_c2", mem_en_a[0], 1'b0);
        chkb("t2_rdy_c2", if_ready_a[0], 1'b0);
        step();
        chkb("t2_rdy_c3", if_ready_a[0], 1'b1);
        chk("t2_rdata_c3", if_rdata_a[0], 32'hDEAD_BEEF);
        chkb("t2_drdy_c3", d_ready_a[0], 1'b0);
        if_req = 1'b0;
        step();
        chkb("t2_rdy_c4", if_ready_a[0], 1'b0);
        chk("t2_rdata_hold", if_rdata_a[0], 32'hDEAD_BEEF);

        // Lone write.
        reset_all();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        step();
        chkb("t3_en_c1", mem_en_a[0], 1'b1);
        chkb("t3_we_c1", mem_we_a[0], 1'b1);
        chk("t3_addr_c1", mem_addr_a[0], 32'h40);
        chk("t3_wdata_c1", mem_wdata_a[0], 32'h1234);
        step();
        chkb("t3_en_c2", mem_en_a[0], 1'b0);
        chkb("t3_rdy_c2", d_ready_a[0], 1'b1);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chkb("t3_rdy_c3", d_ready_a[0], 1'b0);
        chk("t3_drdata", d_rdata_a[0], 32'h0);
        chk("t3_addr_hold", mem_addr_a[0], 32'h40);
        chk("t3_wdata_hold", mem_wdata_a[0], 32'h1234);

        // Continuous contention: RR alternates from IF, fixed priority always picks D.
        reset_all();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h10; d_addr = 32'h44;
        for (int n = 0; n < 24; n++) begin
            if (if_ready_a[0]) seq0.push_back(0);
            if (d_ready_a[0])  seq0.push_back(1);
            if (if_ready_a[2]) seq2.push_back(0);
            if (d_ready_a[2])  seq2.push_back(1);
            step();
        end
        chk("t4_rr_count", 32'(seq0.size()), 32'd6);
        chk("t4_fix_count", 32'(seq2.size()), 32'd6);
        foreach (seq0[i]) chk("t4_rr_order", 32'(seq0[i]), 32'(i % 2));
        foreach (seq2[i]) chk("t4_fix_order", 32'(seq2[i]), 32'd1);
        chk("t4_rr_ifdata", if_rdata_a[0], mem_val(32'h10));
        chk("t4_rr_ddata", d_rdata_a[0], mem_val(32'h44));
        chk("t4_fix_ifdata", if_rdata_a[2], 32'h0);
        if_req = 1'b0; d_req = 1'b0;

        // LAT4 read.
        reset_all();
        if_req = 1'b1; if_addr = 32'h88;
        en_cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (mem_en_a[1]) begin
                en_cnt++;
                chk("t5_en_cycle", 32'(n), 32'd1);
            end
            chkb("t5_ready", if_ready_a[1], n == 6);
            if (n == 6) begin
                chk("t5_rdata", if_rdata_a[1], mem_val(32'h88));
                if_req = 1'b0;
            end
        end
        chk("t5_en_count", 32'(en_cnt), 32'd1);

        // Data requester drops req during WAIT; a fresh fetch is the only live request after.
        reset_all();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        step();
        step();
        d_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h30;
        d_cnt = 0; d_cyc = -1; en_cnt = 0; en_cyc = -1;
        for (int n = 4; n <= 13; n++) begin
            step();
            if (d_ready_a[1]) begin
                d_cnt++;
                d_cyc = n;
                chk("t6_drdata", d_rdata_a[1], mem_val(32'h24));
            end
            if (mem_en_a[1]) begin
                en_cnt++;
                en_cyc = n;
                chk("t6_next_addr", mem_addr_a[1], 32'h30);
            end
            chkb("t6_if_ready", if_ready_a[1], n == 13);
        end
        if_req = 1'b0;
        chk("t6_d_count", 32'(d_cnt), 32'd1);
        chk("t6_d_cycle", 32'(d_cyc), 32'd6);
        chk("t6_en_count", 32'(en_cnt), 32'd1);
        chk("t6_en_cycle", 32'(en_cyc), 32'd8);

        // Randomized traffic against the reference model on each configuration.
        for (int k = 0; k < NI; k++) run_random(k, 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
